// File: rtl/debug_bus_pkg.sv
// Shared types and constants for the debug bus arbiter.
// Holds the FSM state encoding, bus widths and the register-file address map.
package debug_bus_pkg;
    localparam int NUM_REQ_DEF = 3;
    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 32;

    localparam logic [ADDR_W-1:0] RO_BASE    = 16'h0000;
    localparam logic [ADDR_W-1:0] RW_BASE    = 16'h0008;
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = 16'h0010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_e;

    // Out of range, or a write landing in the read-only window below RW_BASE.
    function automatic logic cmd_is_err(input logic we, input logic [ADDR_W-1:0] addr);
        return (addr >= ADDR_LIMIT) ||
               (we && ((addr & ~(RW_BASE - RO_BASE - 16'd1)) == RO_BASE));
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: searches upward from the requester after the last winner.
// The pointer only advances when the caller reports an accept.
module rr_arbiter
    import debug_bus_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               accept_i,
    output logic [NUM_REQ-1:0] grant_o
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] win_idx;
    logic             found;
    int               cand;

    always_comb begin
        grant_o = '0;
        win_idx = ptr_q;
        found   = 1'b0;
        cand    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && (i == cand) && req_i[i]) begin
                    found      = 1'b1;
                    grant_o[i] = 1'b1;
                    win_idx    = IDX_W'(i);
                end
            end
        end
    end

    // Reset to the top index so requester 0 is first in line.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= IDX_W'(NUM_REQ - 1);
        end else if (accept_i && found) begin
            ptr_q <= win_idx;
        end
    end
endmodule

// File: rtl/debug_bus_arbiter.sv
// Arbitrates debug requesters onto a single register-file bus, one command at a time.
// Every output is a register; illegal commands are answered without a bus cycle.
module debug_bus_arbiter
    import debug_bus_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic                      ram_we,
    output logic [DATA_W-1:0]         ram_datain,
    output logic                      ram_enable,
    input  logic [DATA_W-1:0]         ram_dataout
);
    state_e              state_q;
    logic [NUM_REQ-1:0]  owner_q;
    logic                cmd_we_q;
    logic [NUM_REQ-1:0]  req_ready_q;
    logic [NUM_REQ-1:0]  rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_err_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic                ram_we_q;
    logic [DATA_W-1:0]   ram_datain_q;
    logic                ram_enable_q;

    logic [NUM_REQ-1:0]  grant;
    logic                accept;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_err;

    assign accept = (state_q == ST_IDLE) && (|req_valid);

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req_valid),
        .accept_i (accept),
        .grant_o  (grant)
    );

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_we    = req_we[i];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
        sel_err = cmd_is_err(sel_we, sel_addr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            cmd_we_q     <= 1'b0;
            req_ready_q  <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
            ram_addr_q   <= '0;
            ram_we_q     <= 1'b0;
            ram_datain_q <= '0;
            ram_enable_q <= 1'b0;
        end else begin
            req_ready_q  <= '0;
            rsp_valid_q  <= '0;
            ram_enable_q <= 1'b0;
            ram_we_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (|req_valid) begin
                        req_ready_q <= grant;
                        owner_q     <= grant;
                        cmd_we_q    <= sel_we;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= sel_err;
                        if (sel_err) begin
                            state_q <= ST_RESP;
                        end else begin
                            // Bus strobe launches alongside req_ready, covering the ISSUE cycle.
                            state_q      <= ST_ISSUE;
                            ram_enable_q <= 1'b1;
                            ram_we_q     <= sel_we;
                            ram_addr_q   <= sel_addr;
                            ram_datain_q <= sel_wdata;
                        end
                    end
                end
                ST_ISSUE: state_q <= cmd_we_q ? ST_RESP : ST_WAIT;
                ST_WAIT: begin
                    rsp_rdata_q <= ram_dataout;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    rsp_valid_q <= owner_q;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_err    = rsp_err_q;
    assign ram_addr   = ram_addr_q;
    assign ram_we     = ram_we_q;
    assign ram_datain = ram_datain_q;
    assign ram_enable = ram_enable_q;
endmodule

// File: tb/tb_debug_bus_arbiter.sv
// Bench for debug_bus_arbiter: directed command table, fairness and reset
// sequences, then random traffic against a transaction-level reference model.
module tb_debug_bus_arbiter;
    localparam int N = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_we;
    logic [N*16-1:0] req_addr;
    logic [N*32-1:0] req_wdata;
    logic [N-1:0]    req_ready, rsp_valid;
    logic [31:0]     rsp_rdata;
    logic            rsp_err;
    logic [15:0]     ram_addr;
    logic            ram_we;
    logic [31:0]     ram_datain;
    logic            ram_enable;
    logic [31:0]     ram_dataout;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    debug_bus_arbiter #(.NUM_REQ(N)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_datain(ram_datain), .ram_enable(ram_enable),
        .ram_dataout(ram_dataout)
    );

    function automatic logic [31:0] init_word(input int a);
        if (a == 9) return 32'h12345678;
        if (a == 0) return 32'h00C0FFEE;
        return 32'hBEEF0000 | 32'(a);
    endfunction

    // Register file: registered read data one cycle after the enabled cycle.
    logic [31:0] mem [16];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
            ram_dataout <= '0;
        end else if (ram_enable) begin
            if (ram_we) mem[ram_addr[3:0]] <= ram_datain;
            ram_dataout <= mem[ram_addr[3:0]];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input int i, input logic v, input logic we,
                         input logic [15:0] a, input logic [31:0] d);
        req_valid[i]          = v;
        req_we[i]             = we;
        req_addr[i*16 +: 16]  = a;
        req_wdata[i*32 +: 32] = d;
    endtask

    task automatic wait_ready(input string nm, input logic [N-1:0] exp);
        int w;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (req_ready == '0 && w < 10);
        chk(nm, 32'(req_ready), 32'(exp));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_ram_addr", 32'(ram_addr), 0);
        chk("rst_ram_we", 32'(ram_we), 0);
        chk("rst_ram_datain", ram_datain, 0);
        chk("rst_ram_enable", 32'(ram_enable), 0);
        rst = 1'b0;
    endtask

    typedef struct {
        int          rq;
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic        err;
        logic [31:0] rdata;
        int          n_en;
    } vec_t;

    task automatic run_cmd(input int j, input vec_t v);
        int          lat, en_cnt;
        logic        got, ewe;
        logic [15:0] ea;
        logic [31:0] ed;
        drive(v.rq, 1'b1, v.we, v.addr, v.wdata);
        wait_ready($sformatf("v%0d_ready", j), N'(1 << v.rq));
        drive(v.rq, 1'b0, 1'b0, 16'h0, 32'h0);
        en_cnt = 0; got = 1'b0; lat = -1; ewe = 1'b0; ea = '0; ed = '0;
        for (int k = 0; k < 8 && !got; k++) begin
            if (k > 0) @(negedge clk);
            if (ram_enable) begin
                en_cnt++; ea = ram_addr; ewe = ram_we; ed = ram_datain;
            end else if (ram_we) begin
                chk($sformatf("v%0d_ram_we_idle", j), 32'(ram_we), 0);
            end
            if (rsp_valid != '0) begin
                got = 1'b1;
                lat = k;
                chk($sformatf("v%0d_rsp_valid", j), 32'(rsp_valid), 32'(1 << v.rq));
                chk($sformatf("v%0d_rsp_err", j), 32'(rsp_err), 32'(v.err));
                if (!v.we || v.err) chk($sformatf("v%0d_rsp_rdata", j), rsp_rdata, v.rdata);
            end
        end
        chk($sformatf("v%0d_latency", j), 32'(lat), 32'(v.lat));
        chk($sformatf("v%0d_en_cycles", j), 32'(en_cnt), 32'(v.n_en));
        if (v.n_en > 0) begin
            chk($sformatf("v%0d_ram_addr", j), 32'(ea), 32'(v.addr));
            chk($sformatf("v%0d_ram_we", j), 32'(ewe), 32'(v.we));
            if (v.we) chk($sformatf("v%0d_ram_datain", j), ed, v.wdata);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vec_t        vt[11];
        logic [31:0] ref_mem [16];
        logic        c_v [N];
        logic        c_we [N];
        logic [15:0] c_addr [N];
        logic [31:0] c_wd [N];
        int          last, next_ok, rsp_at, own;
        logic        own_we, own_err;
        logic [31:0] own_rd;

        vt[0]  = '{1, 1'b0, 16'h0009, 32'h0,        3, 1'b0, 32'h12345678, 1};
        vt[1]  = '{0, 1'b1, 16'h000F, 32'hDEADBEEF, 2, 1'b0, 32'h0,        1};
        vt[2]  = '{2, 1'b1, 16'h0003, 32'h11111111, 1, 1'b1, 32'h0,        0};
        vt[3]  = '{0, 1'b0, 16'h0010, 32'h0,        1, 1'b1, 32'h0,        0};
        vt[4]  = '{2, 1'b0, 16'h000F, 32'h0,        3, 1'b0, 32'hDEADBEEF, 1};
        vt[5]  = '{1, 1'b1, 16'h0008, 32'hA5A5A5A5, 2, 1'b0, 32'h0,        1};
        vt[6]  = '{0, 1'b1, 16'h0007, 32'h22222222, 1, 1'b1, 32'h0,        0};
        vt[7]  = '{1, 1'b0, 16'h0000, 32'h0,        3, 1'b0, 32'h00C0FFEE, 1};
        vt[8]  = '{2, 1'b0, 16'hFFFF, 32'h0,        1, 1'b1, 32'h0,        0};
        vt[9]  = '{0, 1'b1, 16'h0010, 32'h33333333, 1, 1'b1, 32'h0,        0};
        vt[10] = '{0, 1'b0, 16'h0008, 32'h0,        3, 1'b0, 32'hA5A5A5A5, 1};

        rst = 1'b1;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        do_reset();
        for (int j = 0; j < 11; j++) run_cmd(j, vt[j]);

        // Fairness: all three hold reads from reset.
        do_reset();
        for (int i = 0; i < N; i++) drive(i, 1'b1, 1'b0, 16'(i + 1), 32'h0);
        wait_ready("fair_g0", 3'b001);
        wait_ready("fair_g1", 3'b010);
        wait_ready("fair_g2", 3'b100);
        wait_ready("fair_g3", 3'b001);
        req_valid = '0;
        repeat (6) @(negedge clk);

        // Reset during the WAIT cycle of a read from requester 1.
        do_reset();
        drive(1, 1'b1, 1'b0, 16'h0009, 32'h0);
        wait_ready("rstmid_ready", 3'b010);
        drive(1, 1'b0, 1'b0, 16'h0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rstmid_rsp_valid", 32'(rsp_valid), 0);
            chk("rstmid_ram_enable", 32'(ram_enable), 0);
            chk("rstmid_req_ready", 32'(req_ready), 0);
            chk("rstmid_rsp_rdata", rsp_rdata, 0);
            chk("rstmid_rsp_err", 32'(rsp_err), 0);
            chk("rstmid_ram_addr", 32'(ram_addr), 0);
            chk("rstmid_ram_we", 32'(ram_we), 0);
            chk("rstmid_ram_datain", ram_datain, 0);
        end
        rst = 1'b0;
        for (int i = 0; i < N; i++) drive(i, 1'b1, 1'b0, 16'h0001, 32'h0);
        wait_ready("rstmid_next_grant", 3'b001);
        req_valid = '0;
        repeat (6) @(negedge clk);

        // Random traffic against a transaction-level model.
        do_reset();
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        for (int i = 0; i < N; i++) begin
            c_v[i] = 1'b0; c_we[i] = 1'b0; c_addr[i] = '0; c_wd[i] = '0;
        end
        last = N - 1; next_ok = 0; rsp_at = -1; own = 0;
        own_we = 1'b0; own_err = 1'b0; own_rd = '0;
        for (int n = 0; n < 3000; n++) begin
            int          g, lat;
            logic        eerr;
            logic [15:0] a;
            @(negedge clk);
            chk("rnd_rsp_valid", 32'(rsp_valid), (n == rsp_at) ? 32'(1 << own) : 32'h0);
            if (n == rsp_at) begin
                chk("rnd_rsp_err", 32'(rsp_err), 32'(own_err));
                if (!own_we || own_err) chk("rnd_rsp_rdata", rsp_rdata, own_rd);
            end
            g = -1;
            if (n >= next_ok) begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (last + k) % N;
                    if (g < 0 && c_v[c]) g = c;
                end
            end
            chk("rnd_req_ready", 32'(req_ready), (g >= 0) ? 32'(1 << g) : 32'h0);
            if (g >= 0) begin
                a    = c_addr[g];
                eerr = (a >= 16'h10) || (c_we[g] && a < 16'h8);
                chk("rnd_ram_enable", 32'(ram_enable), 32'(!eerr));
                if (!eerr) begin
                    chk("rnd_ram_addr", 32'(ram_addr), 32'(a));
                    chk("rnd_ram_we", 32'(ram_we), 32'(c_we[g]));
                    if (c_we[g]) chk("rnd_ram_datain", ram_datain, c_wd[g]);
                end
                lat    = eerr ? 1 : (c_we[g] ? 2 : 3);
                own_rd = eerr ? 32'h0 : ref_mem[a[3:0]];
                if (!eerr && c_we[g]) ref_mem[a[3:0]] = c_wd[g];
                own = g; own_we = c_we[g]; own_err = eerr;
                rsp_at = n + lat; next_ok = n + lat + 1; last = g;
            end else begin
                chk("rnd_ram_enable_idle", 32'(ram_enable), 0);
                chk("rnd_ram_we_idle", 32'(ram_we), 0);
            end
            for (int i = 0; i < N; i++) begin
                if (!c_v[i] || req_ready[i]) begin
                    c_v[i]    = (!c_v[i]) ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 60);
                    c_we[i]   = 1'($urandom_range(0, 1));
                    c_addr[i] = 16'($urandom_range(0, 19));
                    c_wd[i]   = $urandom;
                    drive(i, c_v[i], c_we[i], c_addr[i], c_wd[i]);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
